hs_packet_rx: RTL and testbench

Host-side receiver for the processed-sample stream that the interfacing/processing unit emits (`Data`, `Invalid`, `Packet_Done`, `Finish`). It reassembles the stream into 12-sample packets and checks packet alignment and frame length. Each packet goes into one of two ping-pong banks and is offered to host logic through a valid/ready read port, together with per-packet sum, maximum and index. It replaces the plain write-everything host path wherever packets must be consumed with back-pressure.

---
 rtl/hs_packet_rx.sv | 173 +++++++++++++++++
 tb/tb_hs_packet_rx.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_packet_rx.sv
// Host-side packet receiver: reassembles the processed-sample stream into
// ping-pong packet banks offered through a valid/ready read port.
module hs_packet_rx #(
  parameter int DW      = 16,
  parameter int PKT_LEN = 12,
  parameter int PKTS    = 32,
  parameter int SUMW    = 20
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [DW-1:0]   Data,
  input  logic            Invalid,
  input  logic            Packet_Done,
  input  logic            Finish,
  output logic            pkt_valid,
  input  logic            pkt_ready,
  input  logic [3:0]      pkt_rd_addr,
  output logic [DW-1:0]   pkt_rd_data,
  output logic [SUMW-1:0] pkt_sum,
  output logic [DW-1:0]   pkt_max,
  output logic [4:0]      pkt_index,
  output logic            frame_done,
  output logic            err_align,
  output logic            err_overrun,
  output logic            err_short
);

  localparam int SW = $clog2(PKT_LEN);
  localparam int PW = $clog2(PKTS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DRAIN,
    DONE
  } state_t;

  state_t            state_q;
  logic [SW-1:0]     scnt_q;
  logic [PW-1:0]     pcnt_q;
  logic              f_q;
  logic              r_q;
  logic [1:0]        full_q;
  logic              drop_q;
  logic [SUMW-1:0]   acc_sum_q;
  logic [DW-1:0]     acc_max_q;
  logic              frame_done_q;
  logic              err_align_q;
  logic              err_overrun_q;
  logic              err_short_q;

  logic [DW-1:0]     mem_q [2][PKT_LEN];
  logic [SUMW-1:0]   sum_q [2];
  logic [DW-1:0]     max_q [2];
  logic [4:0]        idx_q [2];

  logic              accept;
  logic              first;
  logic              last;
  logic              rel;
  logic [1:0]        full_rel;
  logic [1:0]        full_d;
  logic              drop_now;
  logic              close_ok;
  logic              wr;
  logic [SUMW-1:0]   sum_nx;
  logic [DW-1:0]     max_nx;
  logic              addr_ok;

  assign accept = !Invalid && !Finish &&
                  (state_q == IDLE || state_q == RECV);
  assign first  = (scnt_q == '0);
  assign last   = (scnt_q == SW'(PKT_LEN - 1));
  assign rel    = pkt_valid && pkt_ready;

  // Release frees a bank before the fill check sees it.
  always_comb begin
    full_rel = full_q;
    if (rel) full_rel[r_q] = 1'b0;
    drop_now = first ? full_rel[f_q] : drop_q;
    close_ok = accept && last && !drop_now;
    wr       = accept && !drop_now;
    full_d   = full_rel;
    if (close_ok) full_d[f_q] = 1'b1;
  end

  always_comb begin
    sum_nx = first ? SUMW'(Data) : acc_sum_q + SUMW'(Data);
    max_nx = Data;
    if (!first && acc_max_q > Data) max_nx = acc_max_q;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      scnt_q        <= '0;
      pcnt_q        <= '0;
      f_q           <= 1'b0;
      r_q           <= 1'b0;
      full_q        <= '0;
      drop_q        <= 1'b0;
      acc_sum_q     <= '0;
      acc_max_q     <= '0;
      frame_done_q  <= 1'b0;
      err_align_q   <= 1'b0;
      err_overrun_q <= 1'b0;
      err_short_q   <= 1'b0;
    end else begin
      full_q <= full_d;
      if (rel) r_q <= ~r_q;
      unique case (state_q)
        IDLE, RECV: begin
          if (state_q == RECV && Finish) begin
            if (pcnt_q != PW'(PKTS) || !first)
              err_short_q <= 1'b1;
            scnt_q  <= '0;
            drop_q  <= 1'b0;
            state_q <= DRAIN;
          end else if (accept) begin
            state_q   <= RECV;
            acc_sum_q <= sum_nx;
            acc_max_q <= max_nx;
            if (Packet_Done != last)
              err_align_q <= 1'b1;
            if (first && full_rel[f_q])
              err_overrun_q <= 1'b1;
            if (last) begin
              scnt_q <= '0;
              pcnt_q <= pcnt_q + PW'(1);
              drop_q <= 1'b0;
              if (!drop_now) f_q <= ~f_q;
            end else begin
              scnt_q <= scnt_q + SW'(1);
              drop_q <= drop_now;
            end
          end
        end
        DRAIN: begin
          if (full_q == '0) state_q <= DONE;
        end
        DONE: begin
          frame_done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bank payload needs no reset: it is only visible behind a full flag.
  always_ff @(posedge clk) begin
    if (wr) mem_q[f_q][scnt_q] <= Data;
    if (close_ok) begin
      sum_q[f_q] <= sum_nx;
      max_q[f_q] <= max_nx;
      idx_q[f_q] <= pcnt_q[4:0];
    end
  end

  assign pkt_valid = full_q[r_q];
  assign addr_ok   = 32'(pkt_rd_addr) < PKT_LEN;

  assign pkt_rd_data = (pkt_valid && addr_ok) ?
                       mem_q[r_q][pkt_rd_addr] : '0;
  assign pkt_sum     = pkt_valid ? sum_q[r_q] : '0;
  assign pkt_max     = pkt_valid ? max_q[r_q] : '0;
  assign pkt_index   = pkt_valid ? idx_q[r_q] : '0;

  assign frame_done  = frame_done_q;
  assign err_align   = err_align_q;
  assign err_overrun = err_overrun_q;
  assign err_short   = err_short_q;

endmodule

// File: tb/tb_hs_packet_rx.sv
// Bench for hs_packet_rx: expected packets are queued as stimulus is
// driven and popped by a monitor on every read-port handshake.
module tb_hs_packet_rx;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int DW   = 16;
  localparam int SUMW = 20;

  logic            clk = 1'b0;
  logic            Reset = 1'b1;
  logic [DW-1:0]   Data = '0;
  logic            Invalid = 1'b1;
  logic            Packet_Done = 1'b0;
  logic            Finish = 1'b0;
  logic            pkt_valid;
  logic            pkt_ready = 1'b1;
  logic [3:0]      pkt_rd_addr = '0;
  logic [DW-1:0]   pkt_rd_data;
  logic [SUMW-1:0] pkt_sum;
  logic [DW-1:0]   pkt_max;
  logic [4:0]      pkt_index;
  logic            frame_done;
  logic            err_align;
  logic            err_overrun;
  logic            err_short;

  hs_packet_rx dut (
    .clk         (clk),
    .Reset       (Reset),
    .Data        (Data),
    .Invalid     (Invalid),
    .Packet_Done (Packet_Done),
    .Finish      (Finish),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_rd_addr (pkt_rd_addr),
    .pkt_rd_data (pkt_rd_data),
    .pkt_sum     (pkt_sum),
    .pkt_max     (pkt_max),
    .pkt_index   (pkt_index),
    .frame_done  (frame_done),
    .err_align   (err_align),
    .err_overrun (err_overrun),
    .err_short   (err_short)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int sum;
    int max;
    int first;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   rx_cnt = 0;
  int   m_cnt, m_sum, m_max, m_first, m_pkt;

  logic [31:0] mon_s;
  logic [31:0] mon_d0;
  logic [31:0] mon_oob;
  exp_t        mon_e;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!Reset && pkt_valid && pkt_ready) begin
      mon_s = 0;
      for (int a = 0; a < 12; a++) begin
        pkt_rd_addr = 4'(a);
        #0.1;
        mon_s = mon_s + 32'(pkt_rd_data);
        if (a == 0) mon_d0 = 32'(pkt_rd_data);
      end
      pkt_rd_addr = 4'd12;
      #0.1;
      mon_oob = 32'(pkt_rd_data);
      pkt_rd_addr = 4'd0;
      if (q.size() == 0) begin
        chk("unexp_pkt", q.size(), 1);
      end else begin
        mon_e = q.pop_front();
        chk("pkt_index", 32'(pkt_index), mon_e.idx);
        chk("pkt_sum", 32'(pkt_sum), mon_e.sum);
        chk("pkt_max", 32'(pkt_max), mon_e.max);
        chk("rd_sum", mon_s, mon_e.sum);
        chk("rd_data0", mon_d0, mon_e.first);
        chk("rd_oob", mon_oob, 0);
      end
      rx_cnt++;
    end
  end

  task automatic send(int d, bit pd, bit keep);
    @(posedge clk);
    #1;
    Data        = DW'(d);
    Invalid     = 1'b0;
    Packet_Done = pd;
    Finish      = 1'b0;
    if (m_cnt == 0) begin
      m_sum   = 0;
      m_max   = 0;
      m_first = d;
    end
    m_sum += d;
    if (d > m_max) m_max = d;
    m_cnt++;
    if (m_cnt == 12) begin
      if (keep) q.push_back('{m_pkt, m_sum, m_max, m_first});
      m_pkt++;
      m_cnt = 0;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      Invalid     = 1'b1;
      Data        = 16'hFFFF;
      Packet_Done = 1'b0;
      Finish      = 1'b0;
    end
  endtask

  task automatic finish_frame();
    @(posedge clk);
    #1;
    Invalid = 1'b1;
    Finish  = 1'b1;
    @(posedge clk);
    #1;
    Finish  = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (frame_done) break;
    end
    chk("frame_done", 32'(frame_done), 1);
  endtask

  task automatic do_reset();
    chk("q_empty", q.size(), 0);
    q.delete();
    @(posedge clk);
    #1;
    Reset       = 1'b1;
    Invalid     = 1'b1;
    Packet_Done = 1'b0;
    Finish      = 1'b0;
    pkt_ready   = 1'b1;
    m_cnt  = 0;
    m_pkt  = 0;
    rx_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    m_cnt = 0;
    m_pkt = 0;
    #3;
    chk("rst_valid", 32'(pkt_valid), 0);
    chk("rst_sum", 32'(pkt_sum), 0);
    chk("rst_max", 32'(pkt_max), 0);
    chk("rst_index", 32'(pkt_index), 0);
    chk("rst_rdata", 32'(pkt_rd_data), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_align", 32'(err_align), 0);
    chk("rst_ovr", 32'(err_overrun), 0);
    chk("rst_short", 32'(err_short), 0);
    do_reset();

    // full frame
    for (int k = 0; k < 384; k++) send(k, (k % 12) == 11, 1'b1);
    idle(3);
    finish_frame();
    wait_done();
    chk("ff_align", 32'(err_align), 0);
    chk("ff_ovr", 32'(err_overrun), 0);
    chk("ff_short", 32'(err_short), 0);
    chk("ff_count", rx_cnt, 32);

    // back-pressure: packet 2 finds no free bank
    do_reset();
    pkt_ready = 1'b0;
    for (int k = 0; k < 60; k++) begin
      send(k, (k % 12) == 11, (k / 12) != 2);
      if (k == 36) pkt_ready = 1'b1;
    end
    idle(4);
    chk("bp_ovr", 32'(err_overrun), 1);
    chk("bp_count", rx_cnt, 4);

    // gaps after sample 6
    do_reset();
    for (int k = 0; k < 12; k++) begin
      send(k, k == 11, 1'b1);
      if (k == 5) idle(5);
    end
    @(negedge clk);
    chk("gap_lat_pre", 32'(pkt_valid), 0);
    idle(1);
    @(negedge clk);
    chk("gap_lat_post", 32'(pkt_valid), 1);
    idle(3);
    chk("gap_count", rx_cnt, 1);

    // misaligned marker
    do_reset();
    for (int k = 0; k < 24; k++) send(k, k == 5 || k == 23, 1'b1);
    idle(3);
    chk("mis_align", 32'(err_align), 1);
    chk("mis_count", rx_cnt, 2);

    // short frame
    do_reset();
    for (int k = 0; k < 100; k++) send(k, (k % 12) == 11, 1'b1);
    idle(2);
    finish_frame();
    wait_done();
    chk("sh_short", 32'(err_short), 1);
    chk("sh_count", rx_cnt, 8);

    // reset mid-operation
    do_reset();
    pkt_ready = 1'b0;
    for (int k = 0; k < 30; k++) send(k, (k % 12) == 11, 1'b0);
    @(negedge clk);
    chk("mid_valid_pre", 32'(pkt_valid), 1);
    chk("mid_ovr_pre", 32'(err_overrun), 1);
    #1;
    Reset   = 1'b1;
    Invalid = 1'b1;
    #1;
    chk("mid_valid", 32'(pkt_valid), 0);
    chk("mid_sum", 32'(pkt_sum), 0);
    chk("mid_index", 32'(pkt_index), 0);
    chk("mid_max", 32'(pkt_max), 0);
    chk("mid_ovr", 32'(err_overrun), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    Reset     = 1'b0;
    pkt_ready = 1'b1;
    m_cnt  = 0;
    m_pkt  = 0;
    rx_cnt = 0;
    for (int k = 0; k < 12; k++) send(k, k == 11, 1'b1);
    idle(3);
    chk("mid_count", rx_cnt, 1);
    chk("end_q_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
